// File: rtl/atm_entry_pkg.sv
// atm_entry_pkg: shared definitions for the ATM keypad front-end.
//   - key-code constants for the control keys (digits are 4'h0-4'h9)
//   - session state encoding
//   - default account-number and PIN widths
//   - is_digit helper used by the FSM and the accumulator control
package atm_entry_pkg;

  localparam int ACC_W_DEF = 12;
  localparam int PIN_W_DEF = 4;

  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  typedef enum logic [2:0] {
    ACC_ENTRY = 3'd0,
    PIN_ENTRY = 3'd1,
    REQUEST   = 3'd2,
    WAIT_AUTH = 3'd3,
    SESSION   = 3'd4,
    LOCKED    = 3'd5
  } state_t;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

endpackage

// File: rtl/atm_dec_accum.sv
// atm_dec_accum: decimal x10+d accumulator for the account number.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : clear value and digit count
//   digit_en    : accept 'digit' this cycle unless reject is high
//   digit       : decimal digit 0-9
//   acc         : accumulated value
//   digit_cnt   : number of digits accepted so far
//   reject      : the presented digit would exceed ACC_DIGITS or 2^ACC_W-1
module atm_dec_accum #(
  parameter int ACC_DIGITS = 4,
  parameter int ACC_W      = 12,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             digit_en,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] digit_cnt,
  output logic             reject
);

  // Four extra bits hold acc*10+9 for any acc that fits in ACC_W,
  // so the overflow compare never sees a wrapped value.
  localparam int SUM_W = ACC_W + 4;

  logic [SUM_W-1:0] sum;

  assign sum    = SUM_W'(acc) * SUM_W'(10) + SUM_W'(digit);
  assign reject = (digit_cnt == CNT_W'(ACC_DIGITS)) ||
                  (sum > SUM_W'((1 << ACC_W) - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      acc       <= '0;
      digit_cnt <= '0;
    end else if (digit_en && !reject) begin
      acc       <= sum[ACC_W-1:0];
      digit_cnt <= digit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/atm_card_entry.sv
// atm_card_entry: keypad front-end for the ATM controller.
// Collects an account number and a single-digit PIN, raises an auth request
// (req_valid/req_ready), waits for the verdict, holds the session and locks
// the keypad for LOCK_CYCLES after MAX_TRIES consecutive failures.
//   clk, rst_n     : clock, synchronous active-low reset
//   key_valid/code : keypress strobe and code (0-9, A ENTER, B CLEAR, C CANCEL)
//   req_ready      : downstream accepts the request
//   auth_done/ok   : auth verdict strobe and result
//   logout         : ends an active session
//   acc_number,pin : captured credentials
//   req_valid      : request pending
//   session_active : authenticated session
//   locked         : lockout in progress
//   entry_error    : one-cycle pulse on a rejected key
//   fail_count     : consecutive failed authentications
module atm_card_entry
  import atm_entry_pkg::*;
#(
  parameter int ACC_DIGITS  = 4,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int PIN_W       = PIN_W_DEF,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             req_ready,
  input  logic             auth_done,
  input  logic             auth_ok,
  input  logic             logout,
  output logic [ACC_W-1:0] acc_number,
  output logic [PIN_W-1:0] pin,
  output logic             req_valid,
  output logic             session_active,
  output logic             locked,
  output logic             entry_error,
  output logic [1:0]       fail_count
);

  localparam int CNT_W = $clog2(ACC_DIGITS + 1);
  localparam int TMR_W = $clog2(LOCK_CYCLES);

  state_t           state;
  logic             has_pin;
  logic [TMR_W-1:0] lock_tmr;

  logic             acc_clr;
  logic             acc_digit_en;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_reject;

  // Accumulator control is decoded combinationally so a digit lands in the
  // same edge that samples the key.
  always_comb begin
    acc_clr      = 1'b0;
    acc_digit_en = (state == ACC_ENTRY) && key_valid && is_digit(key_code);
    case (state)
      ACC_ENTRY: acc_clr = key_valid &&
                           (key_code == KEY_CLEAR || key_code == KEY_CANCEL);
      PIN_ENTRY: acc_clr = key_valid && (key_code == KEY_CANCEL);
      WAIT_AUTH: acc_clr = auth_done && !auth_ok;
      SESSION:   acc_clr = logout || (key_valid && key_code == KEY_CANCEL);
      default:   acc_clr = 1'b0;
    endcase
  end

  atm_dec_accum #(
    .ACC_DIGITS (ACC_DIGITS),
    .ACC_W      (ACC_W),
    .CNT_W      (CNT_W)
  ) u_accum (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (acc_clr),
    .digit_en  (acc_digit_en),
    .digit     (key_code),
    .acc       (acc_number),
    .digit_cnt (acc_cnt),
    .reject    (acc_reject)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ACC_ENTRY;
      pin            <= '0;
      has_pin        <= 1'b0;
      req_valid      <= 1'b0;
      session_active <= 1'b0;
      locked         <= 1'b0;
      entry_error    <= 1'b0;
      fail_count     <= '0;
      lock_tmr       <= '0;
    end else begin
      entry_error <= 1'b0;
      case (state)
        ACC_ENTRY: begin
          if (key_valid) begin
            if (is_digit(key_code)) begin
              if (acc_reject) entry_error <= 1'b1;
            end else if (key_code == KEY_ENTER) begin
              if (acc_cnt == '0) entry_error <= 1'b1;
              else               state       <= PIN_ENTRY;
            end else if (key_code == KEY_CANCEL) begin
              pin     <= '0;
              has_pin <= 1'b0;
            end else if (key_code != KEY_CLEAR) begin
              entry_error <= 1'b1;
            end
          end
        end
        PIN_ENTRY: begin
          if (key_valid) begin
            if (is_digit(key_code)) begin
              pin     <= PIN_W'(key_code);
              has_pin <= 1'b1;
            end else if (key_code == KEY_ENTER) begin
              if (!has_pin) begin
                entry_error <= 1'b1;
              end else begin
                state     <= REQUEST;
                req_valid <= 1'b1;
              end
            end else if (key_code == KEY_CLEAR) begin
              pin     <= '0;
              has_pin <= 1'b0;
            end else if (key_code == KEY_CANCEL) begin
              pin     <= '0;
              has_pin <= 1'b0;
              state   <= ACC_ENTRY;
            end else begin
              entry_error <= 1'b1;
            end
          end
        end
        REQUEST: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= WAIT_AUTH;
          end
        end
        WAIT_AUTH: begin
          if (auth_done) begin
            if (auth_ok) begin
              session_active <= 1'b1;
              fail_count     <= '0;
              state          <= SESSION;
            end else begin
              pin        <= '0;
              has_pin    <= 1'b0;
              fail_count <= fail_count + 2'd1;
              if (fail_count == 2'(MAX_TRIES - 1)) begin
                locked   <= 1'b1;
                lock_tmr <= '0;
                state    <= LOCKED;
              end else begin
                state <= ACC_ENTRY;
              end
            end
          end
        end
        SESSION: begin
          if (logout || (key_valid && key_code == KEY_CANCEL)) begin
            session_active <= 1'b0;
            pin            <= '0;
            has_pin        <= 1'b0;
            state          <= ACC_ENTRY;
          end
        end
        LOCKED: begin
          if (lock_tmr == TMR_W'(LOCK_CYCLES - 1)) begin
            locked     <= 1'b0;
            fail_count <= '0;
            lock_tmr   <= '0;
            state      <= ACC_ENTRY;
          end else begin
            lock_tmr <= lock_tmr + TMR_W'(1);
          end
        end
        default: state <= ACC_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_card_entry.sv
module tb_atm_card_entry;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        req_ready = 1'b0;
  logic        auth_done = 1'b0;
  logic        auth_ok = 1'b0;
  logic        logout = 1'b0;
  logic [11:0] acc_number;
  logic [3:0]  pin;
  logic        req_valid;
  logic        session_active;
  logic        locked;
  logic        entry_error;
  logic [1:0]  fail_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  atm_card_entry dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .req_ready      (req_ready),
    .auth_done      (auth_done),
    .auth_ok        (auth_ok),
    .logout         (logout),
    .acc_number     (acc_number),
    .pin            (pin),
    .req_valid      (req_valid),
    .session_active (session_active),
    .locked         (locked),
    .entry_error    (entry_error),
    .fail_count     (fail_count)
  );

  // Key strobe for one cycle; returns at the negedge after the consuming edge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic auth(input logic ok);
    @(negedge clk);
    auth_done = 1'b1;
    auth_ok   = ok;
    @(negedge clk);
    auth_done = 1'b0;
    auth_ok   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({acc_number, pin, req_valid, session_active, locked, entry_error, fail_count} !== 22'd0) begin
      fails++;
      $display("FAIL reset_outputs: got acc=%0d pin=%0d rv=%b sa=%b lk=%b err=%b fc=%0d, expected all 0",
               acc_number, pin, req_valid, session_active, locked, entry_error, fail_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_login;
    req_ready = 1'b1;
    press(4'd2); press(4'd7); press(4'd4); press(4'd9);
    press(4'hA); press(4'd0); press(4'hA);
    tests++;
    if (req_valid !== 1'b1) begin fails++; $display("FAIL login_req_valid: got %b expected 1", req_valid); end
    tests++;
    if (acc_number !== 12'd2749) begin fails++; $display("FAIL login_acc: got %0d expected 2749", acc_number); end
    tests++;
    if (pin !== 4'd0) begin fails++; $display("FAIL login_pin: got %0d expected 0", pin); end
    @(negedge clk);
    tests++;
    if (req_valid !== 1'b0) begin fails++; $display("FAIL login_req_one_cycle: got %b expected 0", req_valid); end
    auth(1'b1);
    tests++;
    if (session_active !== 1'b1) begin fails++; $display("FAIL login_session: got %b expected 1", session_active); end
    tests++;
    if (acc_number !== 12'd2749) begin fails++; $display("FAIL session_acc_held: got %0d expected 2749", acc_number); end
    // logout together with a digit key: logout wins, no error
    @(negedge clk);
    logout = 1'b1; key_valid = 1'b1; key_code = 4'd5;
    @(negedge clk);
    logout = 1'b0; key_valid = 1'b0;
    tests++;
    if (session_active !== 1'b0) begin fails++; $display("FAIL logout_session: got %b expected 0", session_active); end
    tests++;
    if (acc_number !== 12'd0 || entry_error !== 1'b0) begin
      fails++; $display("FAIL logout_clear: got acc=%0d err=%b expected acc=0 err=0", acc_number, entry_error);
    end
    // a stray verdict outside WAIT_AUTH must not count as a failure
    auth(1'b0);
    tests++;
    if (fail_count !== 2'd0) begin fails++; $display("FAIL stray_auth: got fc=%0d expected 0", fail_count); end
  endtask

  task automatic test_overflow;
    logic e;
    press(4'd4); press(4'd0); press(4'd9);
    e = entry_error;
    press(4'd6);
    tests++;
    if (e !== 1'b0 || entry_error !== 1'b1) begin
      fails++; $display("FAIL overflow_err: got prev=%b now=%b expected prev=0 now=1", e, entry_error);
    end
    tests++;
    if (acc_number !== 12'd409) begin fails++; $display("FAIL overflow_acc: got %0d expected 409", acc_number); end
    @(negedge clk);
    tests++;
    if (entry_error !== 1'b0) begin fails++; $display("FAIL overflow_pulse_width: got %b expected 0", entry_error); end
    press(4'hC);
    tests++;
    if (acc_number !== 12'd0) begin fails++; $display("FAIL overflow_cancel: got %0d expected 0", acc_number); end
  endtask

  task automatic test_entry_errors;
    press(4'hA);
    tests++;
    if (entry_error !== 1'b1) begin fails++; $display("FAIL enter_empty: got %b expected 1", entry_error); end
    press(4'd3);
    tests++;
    if (acc_number !== 12'd3 || entry_error !== 1'b0) begin
      fails++; $display("FAIL after_enter_empty: got acc=%0d err=%b expected acc=3 err=0", acc_number, entry_error);
    end
    press(4'hE);
    tests++;
    if (entry_error !== 1'b1 || acc_number !== 12'd3) begin
      fails++; $display("FAIL invalid_key: got err=%b acc=%0d expected err=1 acc=3", entry_error, acc_number);
    end
    press(4'hA);
    press(4'hA);
    tests++;
    if (entry_error !== 1'b1 || req_valid !== 1'b0) begin
      fails++; $display("FAIL pin_enter_empty: got err=%b rv=%b expected err=1 rv=0", entry_error, req_valid);
    end
    press(4'hD);
    tests++;
    if (entry_error !== 1'b1) begin fails++; $display("FAIL pin_invalid_key: got %b expected 1", entry_error); end
    press(4'hC);
    tests++;
    if (acc_number !== 12'd0) begin fails++; $display("FAIL pin_cancel: got %0d expected 0", acc_number); end
  endtask

  task automatic test_clear;
    press(4'd2); press(4'd1); press(4'hB);
    tests++;
    if (acc_number !== 12'd0) begin fails++; $display("FAIL clear_acc: got %0d expected 0", acc_number); end
    press(4'd2); press(4'd1); press(4'd7); press(4'd5);
    tests++;
    if (acc_number !== 12'd2175 || entry_error !== 1'b0) begin
      fails++; $display("FAIL clear_reenter: got acc=%0d err=%b expected acc=2175 err=0", acc_number, entry_error);
    end
    press(4'd1);
    tests++;
    if (entry_error !== 1'b1 || acc_number !== 12'd2175) begin
      fails++; $display("FAIL fifth_digit: got err=%b acc=%0d expected err=1 acc=2175", entry_error, acc_number);
    end
    press(4'hA); press(4'd8); press(4'hC);
    tests++;
    if (acc_number !== 12'd0 || pin !== 4'd0) begin
      fails++; $display("FAIL cancel_in_pin: got acc=%0d pin=%0d expected 0 0", acc_number, pin);
    end
    press(4'd8);
    tests++;
    if (acc_number !== 12'd8) begin fails++; $display("FAIL back_in_acc_entry: got %0d expected 8", acc_number); end
    press(4'hC);
  endtask

  task automatic test_lockout;
    int  cnt;
    logic err_seen;
    req_ready = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      press(4'd1); press(4'hA); press(4'd5); press(4'hA);
      auth(1'b0);
      if (r < 3) begin
        tests++;
        if (fail_count !== 2'(r) || locked !== 1'b0) begin
          fails++; $display("FAIL fail_round_%0d: got fc=%0d lk=%b expected fc=%0d lk=0", r, fail_count, locked, r);
        end
      end
    end
    tests++;
    if (locked !== 1'b1) begin fails++; $display("FAIL lock_entered: got %b expected 1", locked); end
    cnt = 0;
    err_seen = 1'b0;
    while (locked === 1'b1 && cnt < 1100) begin
      cnt++;
      if (entry_error !== 1'b0) err_seen = 1'b1;
      key_valid = (cnt % 5 == 0);
      key_code  = 4'(cnt % 16);
      @(negedge clk);
    end
    key_valid = 1'b0;
    tests++;
    if (cnt !== 1000) begin fails++; $display("FAIL lock_duration: got %0d cycles expected 1000", cnt); end
    tests++;
    if (err_seen !== 1'b0 || acc_number !== 12'd0) begin
      fails++; $display("FAIL lock_keys_ignored: got err_seen=%b acc=%0d expected 0 0", err_seen, acc_number);
    end
    tests++;
    if (fail_count !== 2'd0) begin fails++; $display("FAIL lock_expiry_fc: got %0d expected 0", fail_count); end
    press(4'd6);
    tests++;
    if (acc_number !== 12'd6) begin fails++; $display("FAIL after_lock_entry: got %0d expected 6", acc_number); end
    press(4'hC);
  endtask

  task automatic test_reset_mid_request;
    req_ready = 1'b0;
    press(4'd3); press(4'hA); press(4'd7); press(4'hA);
    repeat (3) @(negedge clk);
    tests++;
    if (req_valid !== 1'b1 || acc_number !== 12'd3 || pin !== 4'd7) begin
      fails++; $display("FAIL request_hold: got rv=%b acc=%0d pin=%0d expected 1 3 7", req_valid, acc_number, pin);
    end
    press(4'd9);
    tests++;
    if (pin !== 4'd7 || req_valid !== 1'b1) begin
      fails++; $display("FAIL request_keys_frozen: got pin=%0d rv=%b expected 7 1", pin, req_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (req_valid !== 1'b0 || acc_number !== 12'd0 || pin !== 4'd0) begin
      fails++; $display("FAIL reset_mid_request: got rv=%b acc=%0d pin=%0d expected 0 0 0", req_valid, acc_number, pin);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_login();
    test_overflow();
    test_entry_errors();
    test_clear();
    test_lockout();
    test_reset_mid_request();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
